// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:2 stream demultiplexer.
package demux_pkg;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } slot_state_e;

  localparam int unsigned DefaultSize = 4;
  localparam int unsigned DefaultCntW = 8;

  localparam logic PortA = 1'b0;
  localparam logic PortB = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slice with a wrapping delivered-transfer counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned SIZE  = DefaultSize,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill,
  input  logic [SIZE-1:0]  fill_data,
  input  logic             ready,
  output logic [SIZE-1:0]  data,
  output logic             valid,
  output logic             slot_ready,
  output logic [CNT_W-1:0] count
);

  slot_state_e      state_q, state_d;
  logic [SIZE-1:0]  data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain;

  assign drain      = (state_q == StFull) && ready;
  assign valid      = (state_q == StFull);
  assign slot_ready = !valid || ready;
  assign data       = data_q;
  assign count      = cnt_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (drain) cnt_d = cnt_q + 1'b1;
    // fill only arrives when slot_ready, so a full slot is never overwritten undrained
    if (fill) data_d = fill_data;
    unique case (state_q)
      StEmpty: if (fill) state_d = StFull;
      StFull:  if (drain && !fill) state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/demux_stream.sv
// 1:2 valid/ready stream demultiplexer: sel steers each accepted word to port A or B.
module demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned SIZE  = DefaultSize,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SIZE-1:0]  in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  output logic [SIZE-1:0]  out_a,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [SIZE-1:0]  out_b,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic a_slot_ready, b_slot_ready;
  logic accept, fill_a, fill_b;

  // in_valid gates the fills, so an unknown sel while idle cannot disturb either slot
  assign in_ready = (sel == PortB) ? b_slot_ready : a_slot_ready;
  assign accept   = in_valid && in_ready;
  assign fill_a   = accept && (sel == PortA);
  assign fill_b   = accept && (sel == PortB);

  demux_slot #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_slot_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill       (fill_a),
    .fill_data  (in),
    .ready      (a_ready),
    .data       (out_a),
    .valid      (a_valid),
    .slot_ready (a_slot_ready),
    .count      (cnt_a)
  );

  demux_slot #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_slot_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill       (fill_b),
    .fill_data  (in),
    .ready      (b_ready),
    .data       (out_b),
    .valid      (b_valid),
    .slot_ready (b_slot_ready),
    .count      (cnt_b)
  );

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: vector table, queue-based reference model, corner sequences.
module tb_demux_stream;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [SIZE-1:0]  in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             sel = 1'b0;
  logic [SIZE-1:0]  out_a, out_b;
  logic             a_valid, b_valid;
  logic             a_ready = 1'b1, b_ready = 1'b1;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  demux_stream #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .out_a    (out_a),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .out_b    (out_b),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
  );

  always #5 clk = ~clk;

  // Reference model: each port is a queue of capacity one plus a delivered count.
  logic [SIZE-1:0] qa[$];
  logic [SIZE-1:0] qb[$];
  logic [SIZE-1:0] last_a, last_b;
  int unsigned     dl_a, dl_b;

  function automatic void model_reset();
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
    dl_a   = 0;
    dl_b   = 0;
  endfunction

  function automatic logic model_ready(input logic s, input logic ar, input logic br);
    if (s) return (qb.size() == 0) || br;
    return (qa.size() == 0) || ar;
  endfunction

  function automatic logic model_edge(input logic [SIZE-1:0] d, input logic s, input logic v,
                                      input logic ar, input logic br);
    logic acc;
    acc = v && model_ready(s, ar, br);
    if (qa.size() > 0 && ar) begin void'(qa.pop_front()); dl_a++; end
    if (qb.size() > 0 && br) begin void'(qb.pop_front()); dl_b++; end
    if (acc) begin
      if (s) begin qb.push_back(d); last_b = d; end
      else   begin qa.push_back(d); last_a = d; end
    end
    return acc;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("out_a", 64'(out_a), 64'(last_a));
    check("a_valid", 64'(a_valid), 64'(qa.size() > 0));
    check("out_b", 64'(out_b), 64'(last_b));
    check("b_valid", 64'(b_valid), 64'(qb.size() > 0));
    check("cnt_a", 64'(cnt_a), 64'(dl_a % 256));
    check("cnt_b", 64'(cnt_b), 64'(dl_b % 256));
  endtask

  // Called #1 after a rising edge; returns whether the model accepted on the next edge.
  task automatic cycle(input logic [SIZE-1:0] d, input logic s, input logic v, input logic ar,
                       input logic br, input bit chk_rdy, output logic acc);
    in = d; sel = s; in_valid = v; a_ready = ar; b_ready = br;
    #1;
    if (chk_rdy) check("in_ready", 64'(in_ready), 64'(model_ready(s, ar, br)));
    @(posedge clk);
    acc = model_edge(d, s, v, ar, br);
    #1;
    check_model();
  endtask

  typedef struct packed {
    logic [SIZE-1:0]  din;
    logic             s, v, ar, br;
    logic             rdy;
    logic [SIZE-1:0]  oa;
    logic             av;
    logic [SIZE-1:0]  ob;
    logic             bv;
    logic [CNT_W-1:0] ca, cb;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic acc;
    logic [SIZE-1:0] r_in;
    logic r_sel, r_v, hold;

    //            din   s     v     ar    br    rdy   oa    av    ob    bv    ca    cb
    tbl[0]  = '{4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 1'b1, 4'h0, 1'b0, 8'd0, 8'd0};
    tbl[1]  = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 8'd1, 8'd0};
    tbl[2]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 4'hF, 1'b1, 8'd1, 8'd0};
    for (int i = 3; i < 8; i++)
      tbl[i] = '{4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 4'hF, 1'b1, 8'd1, 8'd0};
    tbl[8]  = '{4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 4'h3, 1'b1, 8'd1, 8'd1};
    tbl[9]  = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 4'h3, 1'b1, 8'd1, 8'd1};
    tbl[10] = '{4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 4'h3, 1'b1, 8'd1, 8'd1};
    tbl[11] = '{4'hA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h6, 1'b1, 4'hA, 1'b1, 8'd1, 8'd2};
    tbl[12] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 1'b1, 4'hA, 1'b0, 8'd1, 8'd3};
    tbl[13] = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 4'hA, 1'b0, 8'd2, 8'd3};

    // Reset held across two edges
    repeat (2) @(posedge clk);
    #1;
    check("rst out_a", 64'(out_a), 64'h0);
    check("rst a_valid", 64'(a_valid), 64'h0);
    check("rst out_b", 64'(out_b), 64'h0);
    check("rst b_valid", 64'(b_valid), 64'h0);
    check("rst cnt_a", 64'(cnt_a), 64'h0);
    check("rst cnt_b", 64'(cnt_b), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      in = tbl[i].din; sel = tbl[i].s; in_valid = tbl[i].v;
      a_ready = tbl[i].ar; b_ready = tbl[i].br;
      #1;
      check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_a", i), 64'(out_a), 64'(tbl[i].oa));
      check($sformatf("vec%0d a_valid", i), 64'(a_valid), 64'(tbl[i].av));
      check($sformatf("vec%0d out_b", i), 64'(out_b), 64'(tbl[i].ob));
      check($sformatf("vec%0d b_valid", i), 64'(b_valid), 64'(tbl[i].bv));
      check($sformatf("vec%0d cnt_a", i), 64'(cnt_a), 64'(tbl[i].ca));
      check($sformatf("vec%0d cnt_b", i), 64'(cnt_b), 64'(tbl[i].cb));
    end

    // Sync the model to the state the table leaves behind
    model_reset();
    last_a = 4'h6; last_b = 4'hA; dl_a = 2; dl_b = 3;

    // Full throughput: 16 words alternating sel, both consumers ready
    for (int k = 0; k < 16; k++) begin
      cycle(SIZE'($urandom), k[0], 1'b1, 1'b1, 1'b1, 1'b1, acc);
      check("thru accept", 64'(acc), 64'h1);
    end
    cycle('0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    check("thru cnt_a", 64'(cnt_a), 64'd10);
    check("thru cnt_b", 64'(cnt_b), 64'd11);

    // Randomised traffic with producer holding words until accepted
    hold = 1'b0;
    r_in = '0; r_sel = 1'b0; r_v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        r_v   = ($urandom_range(0, 3) != 0);
        r_in  = SIZE'($urandom);
        r_sel = 1'($urandom);
      end
      cycle(r_in, r_sel, r_v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 1'b1,
            acc);
      hold = r_v && !acc;
    end

    // Counter wrap: clean reset, then 257 transfers to port A
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 257; k++) begin
      cycle(SIZE'(k), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
      if (k == 256) check("wrap 255", 64'(cnt_a), 64'd255);
      if (k == 257) check("wrap 0", 64'(cnt_a), 64'd0);
    end
    cycle('0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    check("wrap 1", 64'(cnt_a), 64'd1);

    // Async reset mid-operation with both slots full
    cycle(4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    cycle(4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    check("full a_valid", 64'(a_valid), 64'h1);
    check("full b_valid", 64'(b_valid), 64'h1);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async out_a", 64'(out_a), 64'h0);
    check("async a_valid", 64'(a_valid), 64'h0);
    check("async out_b", 64'(out_b), 64'h0);
    check("async b_valid", 64'(b_valid), 64'h0);
    check("async cnt_a", 64'(cnt_a), 64'h0);
    check("async cnt_b", 64'(cnt_b), 64'h0);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Unknown sel while idle must not disturb held slots
    cycle(4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    cycle(4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    for (int k = 0; k < 4; k++) begin
      cycle(4'hx, 1'bx, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      check("selx out_a", 64'(out_a), 64'hC);
      check("selx out_b", 64'(out_b), 64'h2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Parameterized 1:2 stream demultiplexer with registered outputs.
- One SIZE-bit valid/ready input stream is routed to output port A (SEL=0) or output port B (SEL=1).
- Each output has a one-entry holding register, so backpressure on one port never corrupts the other.
- Per-port transfer counters support bring-up and debug.
- Sits downstream of a producer and fans out to two consumers: the inverse of the team's 2:1 mux.

Parameters:
- SIZE, 4, data width in bits (legal range 1 to 64).
- CNT_W, 8, width of each per-port transfer counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- IN  input  SIZE  input data.
- IN_VALID  input  1  input data valid.
- IN_READY  output  1  block can accept input this cycle.
- SEL  input  1  route select: 0 sends to A, 1 sends to B. Sampled only on an accepted transfer.
- OUT_A  output  SIZE  port A data.
- A_VALID  output  1  port A holding register full.
- A_READY  input  1  port A consumer ready.
- OUT_B  output  SIZE  port B data.
- B_VALID  output  1  port B holding register full.
- B_READY  input  1  port B consumer ready.
- CNT_A  output  CNT_W  transfers delivered to A, wrapping.
- CNT_B  output  CNT_W  transfers delivered to B, wrapping.

Behaviour:
- Reset: RST_N low asynchronously clears OUT_A, OUT_B, A_VALID, B_VALID, CNT_A and CNT_B to 0. Asserting reset mid-operation discards held data immediately.
- Reset release: first possible accept is on the first CLK edge with RST_N high.
- Accept: a transfer happens on a rising edge where IN_VALID && IN_READY.
- IN_READY is combinational:
  - SEL=0: IN_READY = !A_VALID || A_READY
  - SEL=1: IN_READY = !B_VALID || B_READY
  - Does not depend on IN_VALID.
- Latency: data accepted at edge N appears on the selected OUT_x with x_VALID=1 after edge N (1 cycle). The unselected port is unchanged.
- Per-slot two-state machine, EMPTY/FULL:
  - EMPTY -> FULL on fill.
  - FULL -> EMPTY on drain (x_VALID && x_READY) with no fill.
  - FULL stays FULL on simultaneous drain and fill; OUT_x takes the new data with no bubble.
  - FULL with no drain: OUT_x and x_VALID hold stable. The slot is never overwritten.
- Port independence: A stalled (A_VALID=1, A_READY=0) does not block transfers to B when SEL=1, and the reverse.
- Counters:
  - CNT_x increments by 1 on each drain of port x, i.e. on delivery, not on accept.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - Modulo 2^CNT_W unsigned arithmetic.
- Input rules:
  - SEL and IN are don't-care while IN_VALID=0. SEL=x with IN_VALID=0 must cause no state change.
  - SEL must be known while IN_VALID=1. Behaviour with SEL=x while IN_VALID=1 is undefined, and the bench does not check it.
- Input stability: the producer holds IN, SEL and IN_VALID stable until accepted. The block does not check this.
- Reordering: none within a port. Ordering across ports is not preserved, since each port drains independently.

Decomposition:
- Package demux_pkg:
  - slot state encoding (EMPTY=1'b0, FULL=1'b1)
  - default SIZE and CNT_W constants
  - port index constants PORT_A=0, PORT_B=1
- Sub-module demux_slot: one-entry register slice with parameters SIZE and CNT_W.
  - Inputs: fill, data, ready.
  - Outputs: data, valid, slot_ready (!valid || ready), counter.
  - Instantiated twice.
- Top level contains only the SEL steering of fill and IN_READY, plus wiring.

Test Plan (SIZE=4, CNT_W=8):
- Reset then basic route:
  - Stimulus: RST_N low, then release; IN=4'b0101, SEL=0, IN_VALID=1 for one cycle; A_READY=B_READY=1.
  - Required: during reset all outputs 0. One cycle after accept, OUT_A=4'b0101, A_VALID=1; B_VALID stays 0. Then CNT_A=1.
- Route to B under backpressure:
  - Stimulus: B_READY=0; send 4'b1111 with SEL=1, then present 4'b0011 with SEL=1.
  - Required: OUT_B=4'b1111, B_VALID=1, held for 5 cycles; IN_READY=0 for the second word. After B_READY=1: accept, OUT_B=4'b0011 next cycle, no bubble; CNT_B=1.
- Independence:
  - Stimulus: A stalled full with A_READY=0; send 4'b1010 with SEL=1.
  - Required: IN_READY=1, OUT_B=4'b1010 next cycle; OUT_A unchanged.
- Full throughput:
  - Stimulus: both READY=1; 16 back-to-back words alternating SEL.
  - Required: IN_READY=1 every cycle; CNT_A=8, CNT_B=8; per-port order preserved.
- Counter wrap:
  - Stimulus: 257 transfers to port A.
  - Required: CNT_A reads 255 then 0 then 1.
- Async reset mid-operation and SEL=x:
  - Stimulus: with both slots full, pulse RST_N low between edges. Then hold IN_VALID=0 with SEL=1'bx.
  - Required: immediate clear of all outputs without waiting for CLK. With IN_VALID=0, no change for 4 cycles.
